req_encoder: RTL

Round-robin request encoder: the reverse of the bit demultiplexer. Collects up to Num one-bit request pulses, remembers them as pending, and presents them one at a time as a binary index on a valid/ready handshake. Used where several one-hot sources (interrupt lines, stall/exception causes, per-bank completions) must be funnelled into a single indexed consumer, undoing a demux-style one-hot fan-out.

---
 rtl/req_encoder_pkg.sv | 11 +
 rtl/req_encoder_rr_find.sv | 34 +++
 rtl/req_encoder.sv | 79 +++++++
 3 files changed

// File: rtl/req_encoder_pkg.sv
// Shared types for the round-robin request encoder: offer state encoding and default width.
package req_encoder_pkg;

  localparam int unsigned DefLogNum = 3;

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_OFFER = 1'b1
  } state_e;

endpackage

// File: rtl/req_encoder_rr_find.sv
// Circular first-set search: lowest set bit of vector at or above start, wrapping modulo Num.
module req_encoder_rr_find
  import req_encoder_pkg::*;
#(
  parameter  int unsigned LogNum = DefLogNum,
  localparam int unsigned Num    = 2 ** LogNum
) (
  input  logic [Num-1:0]    vector,
  input  logic [LogNum-1:0] start,
  output logic              found,
  output logic [LogNum-1:0] pos
);

  logic [Num-1:0]    rot;
  logic [LogNum-1:0] off;

  // Rotating a doubled copy puts position start at bit 0, so a plain priority scan wraps.
  assign rot = Num'({vector, vector} >> start);

  always_comb begin
    found = 1'b0;
    off   = '0;
    for (int unsigned i = 0; i < Num; i++) begin
      if (rot[i] && !found) begin
        found = 1'b1;
        off   = LogNum'(i);
      end
    end
  end

  // Num is a power of two, so the LogNum-bit add wraps naturally.
  assign pos = start + off;

endmodule

// File: rtl/req_encoder.sv
// Round-robin request encoder: collects one-bit request pulses and offers them one at a time as a binary index.
module req_encoder
  import req_encoder_pkg::*;
#(
  parameter  int unsigned LogNum = DefLogNum,
  localparam int unsigned Num    = 2 ** LogNum
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [Num-1:0]    req,
  input  logic              ready,
  output logic              valid,
  output logic [LogNum-1:0] idx,
  output logic [Num-1:0]    pending
);

  state_e            state_q, state_d;
  logic [LogNum-1:0] ptr;
  logic [Num-1:0]    clr;
  logic [Num-1:0]    pending_next;
  logic [LogNum-1:0] ptr_next;
  logic              accept;
  logic              search;
  logic              found;
  logic [LogNum-1:0] pos;

  assign accept = valid & ready;
  assign search = !valid | accept;

  always_comb begin
    clr = '0;
    if (accept) clr[idx] = 1'b1;
  end

  // A request arriving in the accepting cycle wins over the clear.
  assign pending_next = (pending & ~clr) | req;
  assign ptr_next     = accept ? idx + LogNum'(1) : ptr;

  req_encoder_rr_find #(
    .LogNum(LogNum)
  ) u_find (
    .vector(pending_next),
    .start (ptr_next),
    .found (found),
    .pos   (pos)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (found) state_d = S_OFFER;
      S_OFFER: if (accept) state_d = found ? S_OFFER : S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    valid = (state_q == S_OFFER);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending <= '0;
      ptr     <= '0;
      idx     <= '0;
    end else begin
      pending <= pending_next;
      ptr     <= ptr_next;
      // A stalled offer keeps its index; a new one is only chosen when searching.
      if (search && found) idx <= pos;
    end
  end

endmodule
